md_scheduler: RTL and testbench

- Sequences the shared multiply/divide resource (HI/LO) for the five-stage MIPS pipeline.
- Accepts MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO from the E stage and models fixed multi-cycle latency with a busy FSM and countdown counter.
- Generates the D-stage stall request for any MD-type instruction behind an in-flight operation.
- Honours the CP0 flush request so an excepted instruction never starts or writes HI/LO.

---
 rtl/md_scheduler.sv | 76 +++++++
 tb/tb_md_scheduler.sv | 136 +++++++++++++
 2 files changed

// File: rtl/md_scheduler.sv
// md_scheduler: HI/LO multiply/divide sequencer with fixed-latency busy FSM and D-stage stall generation
module md_scheduler #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  MDOp,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Req,
  input  logic        D_MD,
  output logic        Busy,
  output logic        Start,
  output logic        Stall,
  output logic [31:0] HI,
  output logic [31:0] LO,
  output logic [31:0] MDOut
);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [31:0] thi_q, thi_d, tlo_q, tlo_d, hi_q, hi_d, lo_q, lo_d;
  logic [63:0] mul_s, mul_u, res;
  logic [31:0] a_abs, b_abs, dv_a, dv_b, q, r, sq, sr;
  logic is_div, idle_ok, done;
  // Result of the op presented this cycle; signed divide runs on magnitudes so 0x80000000/-1 wraps cleanly
  always_comb begin
    is_div = MDOp == 4'd3;
    mul_s = {{32{A[31]}}, A} * {{32{B[31]}}, B};
    mul_u = {32'd0, A} * {32'd0, B};
    a_abs = A[31] ? -A : A;
    b_abs = B[31] ? -B : B;
    dv_a = is_div ? a_abs : A;
    dv_b = is_div ? b_abs : B;
    q = dv_b == 32'd0 ? 32'd0 : dv_a / dv_b;
    r = dv_b == 32'd0 ? 32'd0 : dv_a % dv_b;
    sq = (is_div && (A[31] ^ B[31])) ? -q : q;
    sr = (is_div && A[31]) ? -r : r;
    res = MDOp == 4'd1 ? mul_s : MDOp == 4'd2 ? mul_u : B == 32'd0 ? {hi_q, lo_q} : {sr, sq};
  end
  // FSM next state, countdown, HI/LO update selection and combinational outputs
  always_comb begin
    Busy = state_q == BUSY;
    Start = state_q == IDLE && MDOp >= 4'd1 && MDOp <= 4'd4 && !Req;
    idle_ok = state_q == IDLE && !Req;
    done = Busy && cnt_q == 4'd1;
    state_d = Start ? BUSY : done ? IDLE : state_q;
    cnt_d = Start ? (MDOp <= 4'd2 ? 4'(MUL_CYCLES) : 4'(DIV_CYCLES)) : Busy ? cnt_q - 4'd1 : cnt_q;
    {thi_d, tlo_d} = Start ? res : {thi_q, tlo_q};
    hi_d = done ? thi_q : (idle_ok && MDOp == 4'd7) ? A : hi_q;
    lo_d = done ? tlo_q : (idle_ok && MDOp == 4'd8) ? A : lo_q;
    Stall = D_MD && (Busy || Start);
    MDOut = MDOp == 4'd5 ? hi_q : MDOp == 4'd6 ? lo_q : 32'd0;
    HI = hi_q;
    LO = lo_q;
  end
  // State registers; reset discards any pending result
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= 4'd0;
      thi_q <= 32'd0;
      tlo_q <= 32'd0;
      hi_q <= 32'd0;
      lo_q <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      thi_q <= thi_d;
      tlo_q <= tlo_d;
      hi_q <= hi_d;
      lo_q <= lo_d;
    end
  end
endmodule

// File: tb/tb_md_scheduler.sv
// tb_md_scheduler: directed checks of md_scheduler latency, results, flush and stall behaviour
module tb_md_scheduler;
  logic clk = 1'b0, reset = 1'b1, Req = 1'b0, D_MD = 1'b0;
  logic [3:0] MDOp = 4'd0;
  logic [31:0] A = 32'd0, B = 32'd0;
  logic Busy, Start, Stall;
  logic [31:0] HI, LO, MDOut;
  int checks = 0, failures = 0;

  md_scheduler dut (
    .clk(clk), .reset(reset), .MDOp(MDOp), .A(A), .B(B), .Req(Req), .D_MD(D_MD),
    .Busy(Busy), .Start(Start), .Stall(Stall), .HI(HI), .LO(LO), .MDOut(MDOut)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input logic rq, input logic dm);
    @(posedge clk);
    #1;
    MDOp = op; A = a; B = b; Req = rq; D_MD = dm;
    #1;
  endtask

  task automatic issue(input string tag, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int n);
    cyc(op, a, b, 1'b0, 1'b1);
    check({tag, "_start"}, 32'(Start), 32'd1);
    check({tag, "_stall0"}, 32'(Stall), 32'd1);
    check({tag, "_busy0"}, 32'(Busy), 32'd0);
    for (int i = 1; i <= n; i++) begin
      cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      check({tag, "_busy"}, 32'(Busy), 32'd1);
      check({tag, "_stall"}, 32'(Stall), 32'd1);
    end
  endtask

  task automatic finish_op(input string tag, input logic [31:0] hi, input logic [31:0] lo);
    cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    check({tag, "_busy_end"}, 32'(Busy), 32'd0);
    check({tag, "_stall_end"}, 32'(Stall), 32'd0);
    check({tag, "_hi"}, HI, hi);
    check({tag, "_lo"}, LO, lo);
  endtask

  initial begin
    repeat (3) cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_hi", HI, 32'd0);
    check("rst_lo", LO, 32'd0);
    reset = 1'b0;
    cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("idle_stall", 32'(Stall), 32'd0);

    issue("mult", 4'd1, 32'hFFFF_FFFE, 32'd3, 5);
    check("mult_hi_old", HI, 32'd0);
    finish_op("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    cyc(4'd5, 32'd0, 32'd0, 1'b0, 1'b0);
    check("mfhi", MDOut, 32'hFFFF_FFFF);
    cyc(4'd6, 32'd0, 32'd0, 1'b0, 1'b0);
    check("mflo", MDOut, 32'hFFFF_FFFA);
    cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("mdout_none", MDOut, 32'd0);

    issue("divu", 4'd4, 32'd100, 32'd7, 10);
    finish_op("divu", 32'd2, 32'd14);

    issue("div_neg", 4'd3, 32'hFFFF_FFF9, 32'd2, 10);
    finish_op("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

    cyc(4'd7, 32'h1234, 32'd0, 1'b0, 1'b0);
    cyc(4'd8, 32'h5678, 32'd0, 1'b0, 1'b0);
    check("mthi", HI, 32'h1234);
    cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("mtlo", LO, 32'h5678);
    issue("div0", 4'd3, 32'd55, 32'd0, 10);
    finish_op("div0", 32'h1234, 32'h5678);

    issue("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10);
    finish_op("div_ovf", 32'd0, 32'h8000_0000);

    cyc(4'd2, 32'd5, 32'd5, 1'b1, 1'b1);
    check("req_start", 32'(Start), 32'd0);
    check("req_stall", 32'(Stall), 32'd0);
    cyc(4'd7, 32'hDEAD, 32'd0, 1'b1, 1'b0);
    check("req_busy", 32'(Busy), 32'd0);
    cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("req_hi", HI, 32'd0);
    check("req_lo", LO, 32'h8000_0000);

    issue("b2b1", 4'd1, 32'd3, 32'd4, 5);
    cyc(4'd1, 32'd5, 32'd6, 1'b0, 1'b1);
    check("b2b_restart", 32'(Start), 32'd1);
    check("b2b_busy_low", 32'(Busy), 32'd0);
    check("b2b1_lo", LO, 32'd12);
    for (int i = 1; i <= 5; i++) begin
      cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
      check("b2b2_busy", 32'(Busy), 32'd1);
    end
    finish_op("b2b2", 32'd0, 32'd30);

    cyc(4'd2, 32'h0001_0000, 32'h0001_0000, 1'b0, 1'b1);
    check("inj_start", 32'(Start), 32'd1);
    cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    cyc(4'd8, 32'hAAAA, 32'd0, 1'b0, 1'b1);
    check("inj_mtlo_start", 32'(Start), 32'd0);
    cyc(4'd1, 32'd7, 32'd7, 1'b0, 1'b1);
    check("inj_mult_start", 32'(Start), 32'd0);
    check("inj_lo_mid", LO, 32'd30);
    cyc(4'd0, 32'd0, 32'd0, 1'b1, 1'b1);
    check("inj_req_busy", 32'(Busy), 32'd1);
    cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b1);
    check("inj_busy5", 32'(Busy), 32'd1);
    finish_op("inj", 32'd1, 32'd0);

    issue("rst_mid", 4'd3, 32'd100, 32'd7, 3);
    reset = 1'b1;
    cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("rst_mid_busy", 32'(Busy), 32'd0);
    check("rst_mid_hi", HI, 32'd0);
    reset = 1'b0;
    repeat (12) cyc(4'd0, 32'd0, 32'd0, 1'b0, 1'b0);
    check("rst_mid_late_hi", HI, 32'd0);
    check("rst_mid_late_lo", LO, 32'd0);
    check("rst_mid_late_busy", 32'(Busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
